// File: rtl/regfile_scoreboard_if.sv
// Register-file / scoreboard bus between the ID-stage decoders (master)
// and the register file (slave). Read ports are flattened: port i lives at
// rd_addr[i*AW +: AW] and rd_data[i*XLEN +: XLEN].
interface regfile_scoreboard_if #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int NRD   = 2,
    parameter int CNTW  = 16
);
    localparam int AW = $clog2(NREGS);

    logic [NRD*AW-1:0]   rd_addr;
    logic [NRD*XLEN-1:0] rd_data;
    logic [NRD-1:0]      rd_busy;
    logic [NRD-1:0]      rd_en;
    logic                stall;
    logic                issue_v;
    logic [AW-1:0]       issue_rd;
    logic                we;
    logic [AW-1:0]       wa;
    logic [XLEN-1:0]     wd;
    logic [CNTW-1:0]     x0_wr_cnt;

    modport master (
        output rd_addr, rd_en, issue_v, issue_rd, we, wa, wd,
        input  rd_data, rd_busy, stall, x0_wr_cnt
    );

    modport slave (
        input  rd_addr, rd_en, issue_v, issue_rd, we, wa, wd,
        output rd_data, rd_busy, stall, x0_wr_cnt
    );
endinterface

// File: rtl/regfile_scoreboard.sv
// ID-stage register file: NRD combinational read ports, one write port,
// and a one-bit-per-register pending-write scoreboard for long-latency ops.
// Optional macro REGFILE_BYPASS_EN: same-cycle write-through of wd to the
// read ports and same-cycle clear of the busy flag.
module regfile_scoreboard #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int NRD   = 2,
    parameter int CNTW  = 16
) (
    input  logic           clk,
    input  logic           reset,
    regfile_scoreboard_if.slave bus
);
    localparam int AW = $clog2(NREGS);

    logic [XLEN-1:0]     rf [NREGS];
    logic [NREGS-1:0]    sb;
    logic [CNTW-1:0]     cnt;
    logic [NRD*XLEN-1:0] rdata;
    logic [NRD-1:0]      rbusy;

    logic wr_real;
    logic wr_x0;
    logic set_real;

    assign wr_real  = bus.we && (bus.wa != '0);
    assign wr_x0    = bus.we && (bus.wa == '0);
    assign set_real = bus.issue_v && (bus.issue_rd != '0);

    // Register array; entry 0 is never written so it always reads as zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < NREGS; r++) rf[r] <= '0;
        end else if (wr_real) begin
            rf[bus.wa] <= bus.wd;
        end
    end

    // Pending-write bits: writeback clears, issue sets; the set is applied
    // last so a new producer supersedes one retiring in the same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sb <= '0;
        end else begin
            if (wr_real)  sb[bus.wa]       <= 1'b0;
            if (set_real) sb[bus.issue_rd] <= 1'b1;
        end
    end

    // Saturating count of writes aimed at x0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                    cnt <= '0;
        else if (wr_x0 && cnt != '1)  cnt <= cnt + 1'b1;
    end

    // Combinational read ports; x0 and reset force zero data and not-busy.
    always_comb begin
        rdata = '0;
        rbusy = '0;
        for (int i = 0; i < NRD; i++) begin
            if (!reset && bus.rd_addr[i*AW +: AW] != '0) begin
                rdata[i*XLEN +: XLEN] = rf[bus.rd_addr[i*AW +: AW]];
                rbusy[i]              = sb[bus.rd_addr[i*AW +: AW]];
`ifdef REGFILE_BYPASS_EN
                if (bus.we && bus.wa == bus.rd_addr[i*AW +: AW]) begin
                    rdata[i*XLEN +: XLEN] = bus.wd;
                    rbusy[i]              = 1'b0;
                end
`endif
            end
        end
    end

    assign bus.rd_data   = rdata;
    assign bus.rd_busy   = rbusy;
    assign bus.stall     = |(rbusy & bus.rd_en);
    assign bus.x0_wr_cnt = cnt;
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Scoreboard bench for regfile_scoreboard: the driver issues one cycle of
// stimulus at a time, predicts the combinational outputs from a plain array
// model of the register file and pending set, and queues the prediction; the
// monitor pops and compares on the falling edge.
module tb_regfile_scoreboard;
    localparam int XLEN  = 64;
    localparam int NREGS = 16;
    localparam int NRD   = 4;
    localparam int CNTW  = 4;
    localparam int AW    = $clog2(NREGS);
    localparam int CMAX  = (1 << CNTW) - 1;

    typedef struct {
        string               tag;
        logic [NRD*XLEN-1:0] data;
        logic [NRD-1:0]      busy;
        logic                stall;
        logic [CNTW-1:0]     cnt;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;

    regfile_scoreboard_if #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .CNTW(CNTW)) bus ();

    regfile_scoreboard #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .CNTW(CNTW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference model: architectural values, set of pending destinations,
    // and number of x0 writes seen so far.
    logic [XLEN-1:0] m_rf [NREGS];
    bit              m_pend [NREGS];
    int              m_cnt;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic logic [NRD*AW-1:0] addrs(input int a0, a1, a2, a3);
        logic [NRD*AW-1:0] v;
        int a [4];
        a[0] = a0; a[1] = a1; a[2] = a2; a[3] = a3;
        v = '0;
        for (int i = 0; i < NRD; i++) v[i*AW +: AW] = AW'(a[i]);
        return v;
    endfunction

    task automatic model_clear();
        for (int r = 0; r < NREGS; r++) begin
            m_rf[r]   = '0;
            m_pend[r] = 0;
        end
        m_cnt = 0;
    endtask

    // Drive one cycle, predict this cycle's outputs, then advance the model
    // to what the registers will hold after the coming rising edge.
    task automatic cyc(input string tag, input bit r,
                       input logic [NRD*AW-1:0] ra, input logic [NRD-1:0] en,
                       input bit iv, input int ird,
                       input bit w, input int a, input logic [XLEN-1:0] d);
        exp_t e;
        @(posedge clk);
        #1;
        reset        = r;
        bus.rd_addr  = ra;
        bus.rd_en    = en;
        bus.issue_v  = iv;
        bus.issue_rd = AW'(ird);
        bus.we       = w;
        bus.wa       = AW'(a);
        bus.wd       = d;
        if (r) model_clear();
        e.tag   = tag;
        e.data  = '0;
        e.busy  = '0;
        e.stall = 0;
        e.cnt   = CNTW'(m_cnt);
        if (!r) begin
            for (int i = 0; i < NRD; i++) begin
                int s;
                s = int'(ra[i*AW +: AW]);
                if (s != 0) begin
                    e.data[i*XLEN +: XLEN] = m_rf[s];
                    e.busy[i]              = m_pend[s];
`ifdef REGFILE_BYPASS_EN
                    if (w && a == s) begin
                        e.data[i*XLEN +: XLEN] = d;
                        e.busy[i]              = 0;
                    end
`endif
                end
                if (e.busy[i] && en[i]) e.stall = 1;
            end
            if (w && a != 0) begin
                m_rf[a]   = d;
                m_pend[a] = 0;
            end
            if (w && a == 0 && m_cnt < CMAX) m_cnt++;
            if (iv && ird != 0) m_pend[ird] = 1;
        end
        q.push_back(e);
    endtask

    task automatic idle(input string tag, input logic [NRD*AW-1:0] ra, input logic [NRD-1:0] en);
        cyc(tag, 0, ra, en, 0, 0, 0, 0, '0);
    endtask

    // Monitor: the DUT presents a full set of outputs every cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() != 0) begin
                e = q.pop_front();
                n_cmp++;
                if (bus.rd_data !== e.data) begin
                    n_bad++;
                    $display("FAIL %s rd_data got %h want %h", e.tag, bus.rd_data, e.data);
                end
                n_cmp++;
                if (bus.rd_busy !== e.busy) begin
                    n_bad++;
                    $display("FAIL %s rd_busy got %b want %b", e.tag, bus.rd_busy, e.busy);
                end
                n_cmp++;
                if (bus.stall !== e.stall) begin
                    n_bad++;
                    $display("FAIL %s stall got %b want %b", e.tag, bus.stall, e.stall);
                end
                n_cmp++;
                if (bus.x0_wr_cnt !== e.cnt) begin
                    n_bad++;
                    $display("FAIL %s x0_wr_cnt got %0d want %0d", e.tag, bus.x0_wr_cnt, e.cnt);
                end
            end
        end
    end

    initial begin
        int guard;
        model_clear();
        bus.rd_addr = '0; bus.rd_en = '0; bus.issue_v = 0; bus.issue_rd = '0;
        bus.we = 0; bus.wa = '0; bus.wd = '0;

        // Reset state, then out of reset.
        cyc("reset_hold", 1, addrs(1, 2, 3, 4), '1, 0, 0, 0, 0, '0);
        idle("post_reset", addrs(1, 2, 3, 0), '1);

        // Write then read back next cycle.
        cyc("wr3", 0, addrs(3, 0, 0, 0), 4'b0001, 0, 0, 1, 3, 64'hDEADBEEF);
        idle("rd3", addrs(3, 3, 0, 3), 4'b0001);

        // x0 writes: data stays zero, counter counts then saturates.
        for (int k = 0; k < 4; k++)
            cyc("x0_wr", 0, addrs(0, 0, 0, 0), '1, 0, 0, 1, 0, 64'h1234);
        idle("x0_cnt4", addrs(0, 3, 0, 0), '1);
        for (int k = 0; k < CMAX + 3; k++)
            cyc("x0_sat", 0, addrs(0, 0, 0, 0), '1, 0, 0, 1, 0, 64'h1234);
        idle("x0_hold", addrs(0, 0, 0, 0), '1);

        // Load-use hazard on r7 via port 1.
        cyc("iss7", 0, addrs(0, 0, 0, 0), '0, 1, 7, 0, 0, '0);
        idle("haz7", addrs(0, 7, 0, 0), 4'b0010);
        cyc("wb7", 0, addrs(0, 7, 0, 0), 4'b0010, 0, 0, 1, 7, 64'h55);
        idle("after_wb7", addrs(0, 7, 0, 0), 4'b0010);

        // Issue ignored for x0; set and clear collide on r9.
        cyc("iss0", 0, addrs(0, 0, 0, 0), '1, 1, 0, 0, 0, '0);
        cyc("coll9", 0, addrs(9, 0, 0, 0), '1, 1, 9, 1, 9, 64'hA5A5_0000_1111_2222);
        idle("rd9", addrs(9, 9, 0, 0), 4'b0011);

        // Four ports, four distinct registers; a busy port masked by rd_en.
        for (int k = 1; k <= 4; k++)
            cyc("fill", 0, addrs(0, 0, 0, 0), '0, 0, 0, 1, k + 10, {32'hC0DE0000, 32'(k)});
        idle("quad", addrs(11, 12, 13, 14), '1);
        idle("mask9", addrs(11, 9, 13, 14), 4'b1101);
        idle("unmask9", addrs(11, 9, 13, 14), 4'b0010);

        // Reset mid-run with a pending register (r5).
        cyc("iss5", 0, addrs(0, 0, 0, 0), '0, 1, 5, 0, 0, '0);
        idle("busy5", addrs(5, 9, 0, 0), '1);
        cyc("midreset", 1, addrs(5, 9, 11, 3), '1, 1, 6, 1, 4, 64'h77);
        idle("after_reset", addrs(5, 9, 11, 3), '1);

        // Randomized traffic with occasional reset.
        for (int k = 0; k < 400; k++) begin
            logic [XLEN-1:0] d;
            d = {$urandom, $urandom};
            cyc("rand", ($urandom_range(0, 59) == 0),
                NRD*AW'($urandom), NRD'($urandom),
                $urandom_range(0, 1), $urandom_range(0, NREGS - 1),
                ($urandom_range(0, 2) != 0), $urandom_range(0, NREGS - 1), d);
        end
        idle("drain", '0, '0);

        guard = 0;
        while (q.size() != 0 && guard < 20) begin
            @(posedge clk);
            guard++;
        end
        if (q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain queue left %0d want 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
